// File: rtl/mips_regdump.sv
// Debug dump engine for the MIPS register file.
// Walks first..last (wrapping modulo 2**AW) on the register-file read port and
// streams {address, value} pairs over a valid/ready interface. The read port is
// combinational, so the word for nxt_q is captured on the same edge that issues
// the handshake. This sustains one word per cycle while the consumer is ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for start_i; read port parked at address 0
// ST_FETCH | one cycle; read port driven with the first address of the range
// ST_SEND  | word presented on valid_o; read port already on the next address

module mips_regdump #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk_i,
   input  logic          nrst_i,
   input  logic          start_i,
   input  logic [AW-1:0] first_i,
   input  logic [AW-1:0] last_i,
   input  logic          abort_i,
   output logic [AW-1:0] raddr_o,
   input  logic [DW-1:0] rdata_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o,
   output logic          last_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] nxt_q, nxt_d;
   logic [AW-1:0] first_q, first_d;
   logic [AW-1:0] last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          handshake;
   logic          capture;

   assign handshake = valid_q & ready_i;

   // State register, range latches and registered outputs.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q <= ST_IDLE;
         nxt_q   <= '0;
         first_q <= '0;
         last_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nxt_q   <= nxt_d;
         first_q <= first_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath: abort wins over everything, including a handshake.
   always_comb begin
      state_d = state_q;
      nxt_d   = nxt_q;
      first_d = first_q;
      last_d  = last_q;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;
      capture = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               first_d = first_i;
               last_d  = last_i;
               nxt_d   = first_i;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               capture = 1'b1;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (handshake) begin
               if (addr_q == last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  capture = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Capture the word currently on the read port and advance the walk.
      if (capture) begin
         data_d = rdata_i;
         addr_d = nxt_q;
         nxt_d  = nxt_q + 1'b1;
      end
   end

   // Flag outputs follow the state being entered so they are registered.
   always_comb begin
      valid_d = (state_d == ST_SEND);
      busy_d  = (state_d != ST_IDLE);
   end

   assign raddr_o = (state_q == ST_IDLE) ? '0 : nxt_q;
   assign valid_o = valid_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign last_o  = valid_q & (addr_q == last_q);
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_mips_regdump.sv
// Directed testbench for mips_regdump with a behavioural register file.

module tb_mips_regdump;

   logic        clk_i;
   logic        nrst_i;
   logic        start_i;
   logic [4:0]  first_i;
   logic [4:0]  last_i;
   logic        abort_i;
   logic [4:0]  raddr_o;
   logic [31:0] rdata_i;
   logic        valid_o;
   logic        ready_i;
   logic [4:0]  addr_o;
   logic [31:0] data_o;
   logic        last_o;
   logic        busy_o;
   logic        done_o;

   logic [31:0] regs [32];
   int checks;
   int failures;

   mips_regdump #(.DW(32), .AW(5)) dut (
      .clk_i   (clk_i),
      .nrst_i  (nrst_i),
      .start_i (start_i),
      .first_i (first_i),
      .last_i  (last_i),
      .abort_i (abort_i),
      .raddr_o (raddr_o),
      .rdata_i (rdata_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .addr_o  (addr_o),
      .data_o  (data_o),
      .last_o  (last_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   assign rdata_i = regs[raddr_o];

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [31:0] exp_data(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : (32'h1000_0000 + {27'd0, a});
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drives one start pulse; returns one cycle later, during FETCH.
   task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
      start_i = 1'b1;
      first_i = f;
      last_i  = l;
      step();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      nrst_i = 1'b1;
      #1 nrst_i = 1'b0;
      #20;
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (done_o !== 1'b0 || last_o !== 1'b0) begin failures++; $display("FAIL reset_done_last got=%b%b exp=00", done_o, last_o); end
      checks++; if (raddr_o !== 5'd0 || addr_o !== 5'd0) begin failures++; $display("FAIL reset_addr raddr=%0d addr=%0d exp=0", raddr_o, addr_o); end
      checks++; if (data_o !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_o); end
      @(negedge clk_i);
      nrst_i = 1'b1;
      step();
   endtask

   task automatic test_full_dump();
      ready_i = 1'b1;
      start_dump(5'd0, 5'd31);
      checks++; if (busy_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL full_fetch busy=%b valid=%b exp busy=1 valid=0", busy_o, valid_o); end
      checks++; if (raddr_o !== 5'd0) begin failures++; $display("FAIL full_fetch_raddr got=%0d exp=0", raddr_o); end
      step();
      for (int i = 0; i < 32; i++) begin
         checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL full_valid i=%0d got=%b exp=1", i, valid_o); end
         checks++; if (addr_o !== 5'(i)) begin failures++; $display("FAIL full_addr i=%0d got=%0d exp=%0d", i, addr_o, i); end
         checks++; if (data_o !== exp_data(5'(i))) begin failures++; $display("FAIL full_data i=%0d got=%h exp=%h", i, data_o, exp_data(5'(i))); end
         checks++; if (last_o !== (i == 31)) begin failures++; $display("FAIL full_last i=%0d got=%b exp=%b", i, last_o, (i == 31)); end
         checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL full_early_done i=%0d got=%b exp=0", i, done_o); end
         step();
      end
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done_o); end
      checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL full_idle busy=%b valid=%b exp=0", busy_o, valid_o); end
      step();
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL full_done_pulse got=%b exp=0", done_o); end
   endtask

   task automatic test_wrap();
      logic [4:0] seq [4];
      seq[0] = 5'd30; seq[1] = 5'd31; seq[2] = 5'd0; seq[3] = 5'd1;
      ready_i = 1'b1;
      start_dump(5'd30, 5'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (valid_o !== 1'b1 || addr_o !== seq[i]) begin failures++; $display("FAIL wrap_addr i=%0d valid=%b got=%0d exp=%0d", i, valid_o, addr_o, seq[i]); end
         checks++; if (data_o !== exp_data(seq[i])) begin failures++; $display("FAIL wrap_data i=%0d got=%h exp=%h", i, data_o, exp_data(seq[i])); end
         checks++; if (last_o !== (i == 3)) begin failures++; $display("FAIL wrap_last i=%0d got=%b exp=%b", i, last_o, (i == 3)); end
         step();
      end
      checks++; if (done_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL wrap_done done=%b valid=%b exp done=1 valid=0", done_o, valid_o); end
      step();
   endtask

   task automatic test_backpressure();
      logic rdy [6];
      logic [4:0] exp_addr;
      int hs;
      rdy[0] = 1'b0; rdy[1] = 1'b0; rdy[2] = 1'b1; rdy[3] = 1'b0; rdy[4] = 1'b1; rdy[5] = 1'b1;
      exp_addr = 5'd4;
      hs = 0;
      ready_i = 1'b0;
      start_dump(5'd4, 5'd6);
      step();
      for (int k = 0; k < 6; k++) begin
         ready_i = rdy[k];
         checks++; if (valid_o !== 1'b1 || addr_o !== exp_addr) begin failures++; $display("FAIL bp_addr k=%0d valid=%b got=%0d exp=%0d", k, valid_o, addr_o, exp_addr); end
         checks++; if (data_o !== exp_data(exp_addr)) begin failures++; $display("FAIL bp_data k=%0d got=%h exp=%h", k, data_o, exp_data(exp_addr)); end
         checks++; if (last_o !== (exp_addr == 5'd6)) begin failures++; $display("FAIL bp_last k=%0d got=%b exp=%b", k, last_o, (exp_addr == 5'd6)); end
         if (valid_o && ready_i) hs++;
         step();
         if (rdy[k]) exp_addr = exp_addr + 5'd1;
      end
      checks++; if (hs != 3) begin failures++; $display("FAIL bp_handshakes got=%0d exp=3", hs); end
      checks++; if (done_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL bp_done done=%b valid=%b exp done=1 valid=0", done_o, valid_o); end
      ready_i = 1'b1;
      step();
   endtask

   task automatic test_single_restart();
      ready_i = 1'b1;
      start_dump(5'd7, 5'd7);
      step();
      checks++; if (valid_o !== 1'b1 || addr_o !== 5'd7 || last_o !== 1'b1) begin failures++; $display("FAIL single_word valid=%b addr=%0d last=%b exp 1/7/1", valid_o, addr_o, last_o); end
      checks++; if (data_o !== exp_data(5'd7)) begin failures++; $display("FAIL single_data got=%h exp=%h", data_o, exp_data(5'd7)); end
      step();
      checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL single_done done=%b busy=%b exp done=1 busy=0", done_o, busy_o); end
      start_dump(5'd8, 5'd8);
      checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin failures++; $display("FAIL restart_fetch busy=%b done=%b exp busy=1 done=0", busy_o, done_o); end
      step();
      checks++; if (valid_o !== 1'b1 || addr_o !== 5'd8 || last_o !== 1'b1) begin failures++; $display("FAIL restart_word valid=%b addr=%0d last=%b exp 1/8/1", valid_o, addr_o, last_o); end
      checks++; if (data_o !== exp_data(5'd8)) begin failures++; $display("FAIL restart_data got=%h exp=%h", data_o, exp_data(5'd8)); end
      step();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL restart_done got=%b exp=1", done_o); end
      step();
   endtask

   task automatic test_abort();
      ready_i = 1'b1;
      start_dump(5'd0, 5'd31);
      // start during FETCH must be ignored
      start_i = 1'b1; first_i = 5'd20; last_i = 5'd21;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin start_i = 1'b1; first_i = 5'd25; last_i = 5'd25; end
         else start_i = 1'b0;
         checks++; if (valid_o !== 1'b1 || addr_o !== 5'(i)) begin failures++; $display("FAIL abort_walk i=%0d valid=%b got=%0d exp=%0d", i, valid_o, addr_o, i); end
         step();
      end
      start_i = 1'b0;
      checks++; if (valid_o !== 1'b1 || addr_o !== 5'd5) begin failures++; $display("FAIL abort_word5 valid=%b got=%0d exp=5", valid_o, addr_o); end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL abort_idle valid=%b busy=%b exp=0", valid_o, busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL abort_done0 got=%b exp=0", done_o); end
      // abort together with start in IDLE stays idle
      abort_i = 1'b1;
      start_i = 1'b1; first_i = 5'd3; last_i = 5'd3;
      step();
      abort_i = 1'b0;
      start_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL abort_start_idle busy=%b done=%b exp=0", busy_o, done_o); end
      step();
      checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL abort_stays busy=%b valid=%b done=%b exp=0", busy_o, valid_o, done_o); end
   endtask

   task automatic test_reset_mid();
      ready_i = 1'b1;
      start_dump(5'd0, 5'd31);
      step();
      step();
      step();
      checks++; if (valid_o !== 1'b1 || addr_o !== 5'd2) begin failures++; $display("FAIL rmid_pre valid=%b addr=%0d exp 1/2", valid_o, addr_o); end
      #2 nrst_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || last_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL rmid_flags valid=%b busy=%b last=%b done=%b exp=0", valid_o, busy_o, last_o, done_o); end
      checks++; if (raddr_o !== 5'd0 || addr_o !== 5'd0 || data_o !== 32'h0) begin failures++; $display("FAIL rmid_data raddr=%0d addr=%0d data=%h exp=0", raddr_o, addr_o, data_o); end
      @(negedge clk_i);
      nrst_i = 1'b1;
      step();
      checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rmid_nodone got=%b exp=0", done_o); end
      start_dump(5'd3, 5'd4);
      step();
      checks++; if (valid_o !== 1'b1 || addr_o !== 5'd3 || data_o !== exp_data(5'd3)) begin failures++; $display("FAIL rmid_restart0 addr=%0d data=%h exp 3/%h", addr_o, data_o, exp_data(5'd3)); end
      step();
      checks++; if (addr_o !== 5'd4 || last_o !== 1'b1) begin failures++; $display("FAIL rmid_restart1 addr=%0d last=%b exp 4/1", addr_o, last_o); end
      step();
      checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", done_o); end
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      start_i  = 1'b0;
      first_i  = 5'd0;
      last_i   = 5'd0;
      abort_i  = 1'b0;
      ready_i  = 1'b0;
      for (int r = 0; r < 32; r++) regs[r] = exp_data(5'(r));
      test_reset();
      test_full_dump();
      test_wrap();
      test_backpressure();
      test_single_restart();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mips_regdump.md
# mips_regdump

Debug register-file dump engine for the single-cycle MIPS core. On command it acts as an initiator on one register-file read port and walks an address range of the 32×32 register file. It streams each `{address, value}` pair out over a valid/ready interface to the debug transport. It uses the register file's combinational read port and sustains one word per cycle while the consumer holds `ready_i` high. It is used while the core is halted.

## Interface
- `DW`, default 32: register data width.
- `AW`, default 5: register address width; the block walks 2**AW registers.
- `clk_i`  in  1: clock, rising edge.
- `nrst_i`  in  1: reset; asynchronous and active-low.
- `start_i`  in  1: dump request; sampled only in IDLE.
- `first_i`  in  AW: first register address; latched on accepted start.
- `last_i`  in  AW: last register address; latched on accepted start.
- `abort_i`  in  1: synchronous abort; returns the block to IDLE.
- `raddr_o`  out  AW: address driven to the register-file read port.
- `rdata_i`  in  DW: combinational read data for `raddr_o`.
- `valid_o`  out  1: an output word is present.
- `ready_i`  in  1: consumer accepts the word.
- `addr_o`  out  AW: register address of the current word.
- `data_o`  out  DW: register value of the current word.
- `last_o`  out  1: current word is the final word of the dump.
- `busy_o`  out  1: high in FETCH and SEND.
- `done_o`  out  1: one-cycle pulse after the final word's handshake.

## Operation
- State machine states:
  - IDLE: `raddr_o`=0, `valid_o`=0.
  - FETCH: one cycle; `raddr_o`=`nxt_q`.
  - SEND: `valid_o`=1; `raddr_o`=`nxt_q`.
- Accepted start (IDLE & `start_i` & !`abort_i`):
  - Latch `first_i` and `last_i`.
  - `nxt_q`←`first_i`; go to FETCH.
- FETCH → SEND:
  - `data_o`←`rdata_i`, `addr_o`←`nxt_q`.
  - `nxt_q`←`nxt_q`+1, modulo 2**AW.
- Handshake is `valid_o & ready_i`.
- SEND with handshake and `addr_o`≠last:
  - `data_o`←`rdata_i`, `addr_o`←`nxt_q`, `nxt_q`++.
  - Stay in SEND; this gives back-to-back words.
- SEND with handshake and `addr_o`==last:
  - Go to IDLE; `valid_o`←0; `done_o`←1 for one cycle.
- SEND without handshake:
  - `data_o`, `addr_o`, `last_o` and `valid_o` hold stable.
  - `nxt_q` holds.
- `last_o` = `valid_o` & (`addr_o`==latched last).
- Range wrap:
  - `first`>`last` wraps through 2**AW−1 to 0.
  - Word count = ((`last`−`first`) mod 2**AW)+1.
  - `first`==`last` gives exactly one word.
  - A full 32-word dump uses `first`=`last`+1 mod 32.
- Register 0 is emitted as whatever the port returns (0).
- `start_i` while busy is ignored; the latched range is unchanged.
- `abort_i`, in any state, takes priority:
  - Next state IDLE, `valid_o`←0, no `done_o`.
  - A handshake in the abort cycle counts as consumed.
  - `abort_i`+`start_i` in IDLE: remain in IDLE.
- A register-file write during the dump is visible if it lands before the word is captured. Halting the core is the caller's responsibility.

## Timing
- Reset values (asynchronous, active-low):
  - State IDLE.
  - `valid_o`, `last_o`, `busy_o`, `done_o`, `raddr_o`, `addr_o`, `data_o`, `nxt_q` all 0.
  - Latched first/last = 0.
- Start latency:
  - `start_i` sampled at edge E0; FETCH during cycle 1.
  - `valid_o`=1 from cycle 2 after E0, with the word for `first`.
- Throughput: with `ready_i` held high, one word per cycle; an N-word dump finishes in N+1 cycles after start.
- `done_o` is high in the cycle immediately after the final handshake; `busy_o` is low in that same cycle.
- A new start is accepted in the `done_o` cycle.
- Reset asserted mid-dump: outputs drop to reset values immediately (asynchronous); no `done_o`.
- All outputs are registered, except `raddr_o` and `last_o`, which decode from registered state only.

## Test plan
- Full dump:
  - Preload R1..R31 with 0x1000_0000+i; `first`=0, `last`=31; `ready_i`=1.
  - Expect 32 words on consecutive cycles: addr 0..31, data 0 then 0x1000_0001..0x1000_001F.
  - `last_o` high only on addr 31; `done_o` in the next cycle.
- Wrap range:
  - `first`=30, `last`=1.
  - Expect addr sequence 30, 31, 0, 1 (4 words); `last_o` on addr 1.
- Backpressure:
  - `first`=4, `last`=6; `ready_i` toggles 0,0,1,0,1,1.
  - Words stay stable while stalled; exactly 3 handshakes; no duplicated or skipped address.
- Single word and restart:
  - `first`=`last`=7 gives one word with `last_o`=1.
  - `start_i` in the `done_o` cycle with `first`=`last`=8 produces addr 8.
- Abort:
  - `first`=0, `last`=31; assert `abort_i` with `ready_i`=1 while word 5 is presented.
  - `valid_o` is 0 next cycle; `done_o` is never pulsed.
  - `start_i` issued during busy is ignored.
- Reset mid-dump:
  - Drop `nrst_i` asynchronously while in SEND.
  - All outputs read 0 before the next clock edge; a subsequent start behaves normally.
